// File: rtl/qbus_pkg.sv
// Shared definitions for the Q-bus initiator: cycle codes, FSM encoding,
// bus widths and small decode helpers.
package qbus_pkg;

  localparam int TMO_W = 16;
  localparam int VEC_W = 16;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_IAK   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] IOPAGE_HI_DEF = 3'b111;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_SYNC  = 3'd2;
  localparam logic [2:0] ST_STRB  = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;
  localparam logic [2:0] ST_REL   = 3'd5;
  localparam logic [2:0] ST_TERR  = 3'd6;
  localparam logic [2:0] ST_END   = 3'd7;

  // The reserved code runs as an ordinary read.
  function automatic logic [1:0] op_norm(input logic [1:0] op);
    return (op == OP_RSVD) ? OP_READ : op;
  endfunction

  function automatic logic bs_select(input logic [VEC_W-1:0] addr,
                                     input logic [1:0] op,
                                     input logic [2:0] page);
    return (addr[VEC_W-1:VEC_W-3] == page) && (op != OP_IAK);
  endfunction

endpackage

// File: rtl/qbus_if.sv
// Core request/acknowledge port plus the Q-bus pad signals, seen from the
// initiator (master) and from the core/pad side (slave).
interface qbus_if;
  import qbus_pkg::*;

  logic             req;
  logic [1:0]       op;
  logic [VEC_W-1:0] addr;
  logic [VEC_W-1:0] wdata;
  logic             busy;
  logic             ack;
  logic             err;
  logic [VEC_W-1:0] rdata;
  logic [VEC_W-1:0] nAD_out;
  logic             nAD_oe;
  logic [VEC_W-1:0] nAD_in;
  logic             nSYNC;
  logic             nDIN;
  logic             nDOUT;
  logic             nBS;
  logic             nIAKO;
  logic             nRPLY;

  modport master (
    input  req, op, addr, wdata, nAD_in, nRPLY,
    output busy, ack, err, rdata, nAD_out, nAD_oe,
           nSYNC, nDIN, nDOUT, nBS, nIAKO
  );

  modport slave (
    output req, op, addr, wdata, nAD_in, nRPLY,
    input  busy, ack, err, rdata, nAD_out, nAD_oe,
           nSYNC, nDIN, nDOUT, nBS, nIAKO
  );

endinterface

// File: rtl/qbus_sync.sv
// Two-flop synchronizer for an active-low asynchronous input; the output is
// active high and resets to the inactive level.
module qbus_sync (
  input  logic CLK,
  input  logic RST,
  input  logic level_n,
  output logic level
);

  logic [1:0] ff_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ff_r <= 2'b00;
    end else begin
      ff_r <= {ff_r[0], ~level_n};
    end
  end

  assign level = ff_r[1];

endmodule

// File: rtl/qbus_master.sv
// Q-bus initiator: turns a core request into a DATI/DATO/IAK handshake on the
// inverted multiplexed nAD bus, with a per-edge reply timeout.
module qbus_master
  import qbus_pkg::*;
#(
  parameter int         TMO_CYC   = 64,
  parameter logic [2:0] IOPAGE_HI = IOPAGE_HI_DEF
) (
  input logic    CLK,
  input logic    RST,
  qbus_if.master bus
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [2:0]       state_r, state_nx_s;
  logic [1:0]       op_r, op_v_s;
  logic [VEC_W-1:0] addr_r, addr_v_s, wdata_r, wdata_v_s;
  logic [TMO_W-1:0] cnt_r;
  logic             err_r;
  logic [VEC_W-1:0] rdata_r;
  logic             rply_s, bs_sel_s;

  logic nsync_r, ndin_r, ndout_r, nbs_r, niako_r, oe_r, busy_r, ack_r;
  logic nsync_nx_s, ndin_nx_s, ndout_nx_s, nbs_nx_s, niako_nx_s, oe_nx_s, busy_nx_s, ack_nx_s;
  logic [VEC_W-1:0] nad_r, nad_nx_s;

  qbus_sync u_rply_sync (.CLK(CLK), .RST(RST), .level_n(bus.nRPLY), .level(rply_s));

  // Outputs are decoded from the next state and registered, so in IDLE the
  // request fields are taken straight from the port.
  assign op_v_s    = (state_r == ST_IDLE) ? op_norm(bus.op) : op_r;
  assign addr_v_s  = (state_r == ST_IDLE) ? bus.addr  : addr_r;
  assign wdata_v_s = (state_r == ST_IDLE) ? bus.wdata : wdata_r;
  assign bs_sel_s  = bs_select(addr_v_s, op_v_s, IOPAGE_HI);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      nsync_r <= 1'b1;
      ndin_r  <= 1'b1;
      ndout_r <= 1'b1;
      nbs_r   <= 1'b1;
      niako_r <= 1'b1;
      oe_r    <= 1'b0;
      nad_r   <= 16'hFFFF;
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      nsync_r <= nsync_nx_s;
      ndin_r  <= ndin_nx_s;
      ndout_r <= ndout_nx_s;
      nbs_r   <= nbs_nx_s;
      niako_r <= niako_nx_s;
      oe_r    <= oe_nx_s;
      nad_r   <= nad_nx_s;
      busy_r  <= busy_nx_s;
      ack_r   <= ack_nx_s;
    end
  end

  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  if (bus.req) state_nx_s = ST_ADDR; else state_nx_s = ST_IDLE;
      ST_ADDR:  state_nx_s = ST_SYNC;
      ST_SYNC:  state_nx_s = ST_STRB;
      ST_STRB: begin
        if (rply_s)                  state_nx_s = ST_LATCH;
        else if (cnt_r == TMO_LAST)  state_nx_s = ST_TERR;
        else                         state_nx_s = ST_STRB;
      end
      ST_LATCH: state_nx_s = ST_REL;
      ST_REL: begin
        if (!rply_s)                 state_nx_s = ST_END;
        else if (cnt_r == TMO_LAST)  state_nx_s = ST_TERR;
        else                         state_nx_s = ST_REL;
      end
      ST_TERR:  state_nx_s = ST_END;
      ST_END:   state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  always_comb begin
    nsync_nx_s = 1'b1;
    ndin_nx_s  = 1'b1;
    ndout_nx_s = 1'b1;
    nbs_nx_s   = 1'b1;
    niako_nx_s = 1'b1;
    oe_nx_s    = 1'b0;
    nad_nx_s   = 16'hFFFF;
    busy_nx_s  = 1'b0;
    ack_nx_s   = 1'b0;
    case (state_nx_s)
      ST_IDLE: busy_nx_s = 1'b0;
      ST_ADDR: begin
        busy_nx_s = 1'b1;
        nbs_nx_s  = ~bs_sel_s;
        nad_nx_s  = ~addr_v_s;
        if (op_v_s == OP_IAK) oe_nx_s = 1'b0; else oe_nx_s = 1'b1;
      end
      ST_SYNC, ST_STRB, ST_LATCH, ST_REL: begin
        busy_nx_s  = 1'b1;
        nbs_nx_s   = ~bs_sel_s;
        nsync_nx_s = ~((state_nx_s == ST_SYNC) || (state_nx_s == ST_STRB));
        if (op_v_s == OP_WRITE) begin
          oe_nx_s    = 1'b1;
          nad_nx_s   = ~wdata_v_s;
          ndout_nx_s = ~(state_nx_s == ST_STRB);
        end else begin
          oe_nx_s    = 1'b0;
          nad_nx_s   = 16'hFFFF;
          ndin_nx_s  = ~(state_nx_s == ST_STRB);
          niako_nx_s = ~((state_nx_s == ST_STRB) && (op_v_s == OP_IAK));
        end
      end
      ST_TERR: busy_nx_s = 1'b1;
      ST_END:  ack_nx_s  = 1'b1;
      default: busy_nx_s = 1'b0;
    endcase
  end

  // Request latch, per-edge timeout counter, error flag and read data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_r    <= OP_READ;
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      cnt_r   <= 16'h0000;
      err_r   <= 1'b0;
      rdata_r <= 16'h0000;
    end else begin
      if ((state_r == ST_IDLE) && bus.req) begin
        op_r    <= op_norm(bus.op);
        addr_r  <= bus.addr;
        wdata_r <= bus.wdata;
      end
      if (state_nx_s != state_r) begin
        cnt_r <= 16'h0000;
      end else if ((state_r == ST_STRB) || (state_r == ST_REL)) begin
        cnt_r <= cnt_r + 16'd1;
      end
      if ((state_r == ST_IDLE) && bus.req) begin
        err_r <= 1'b0;
      end else if (state_nx_s == ST_TERR) begin
        err_r <= 1'b1;
      end
      // Sample while nDIN is still asserted, on the edge that leaves STRB.
      if ((state_r == ST_STRB) && rply_s && (op_r != OP_WRITE)) begin
        rdata_r <= ~bus.nAD_in;
      end
    end
  end

  assign bus.nSYNC   = nsync_r;
  assign bus.nDIN    = ndin_r;
  assign bus.nDOUT   = ndout_r;
  assign bus.nBS     = nbs_r;
  assign bus.nIAKO   = niako_r;
  assign bus.nAD_oe  = oe_r;
  assign bus.nAD_out = nad_r;
  assign bus.busy    = busy_r;
  assign bus.ack     = ack_r;
  assign bus.err     = err_r;
  assign bus.rdata   = rdata_r;

endmodule

// File: tb/tb_qbus_master.sv
// Directed bench for qbus_master: a behavioural Q-bus responder, a protocol
// monitor and a linear sequence of read/write/IAK/timeout/reset steps.
module tb_qbus_master;
  import qbus_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   tests = 0;
  int   failed = 0;

  qbus_if bus();

  qbus_master #(.TMO_CYC(64), .IOPAGE_HI(3'b111)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder state
  logic        resp_en = 1'b1;
  int          resp_delay = 3;
  logic [15:0] resp_data = 16'h0000;
  logic [15:0] cap_data = 16'h0000;
  int          rcnt = 0;

  // Monitor state
  logic        cur_write = 1'b0;
  int          ack_cnt = 0, viol = 0;
  logic        oe_prev = 1'b0, sync_prev = 1'b1, din_prev = 1'b1;
  int          oe_lo_run = 0, gap_oe = 0, sync_hi_run = 0, sync_gap = 0;
  int          din_lo_run = 0, din_lo_len = 0;
  logic [15:0] addr_seen = 16'h0000, dout_data = 16'h0000;
  logic        bs_seen = 1'b1, iak_seen = 1'b0;

  // Responder: replies resp_delay cycles after a data strobe, releases when it drops.
  initial begin
    bus.nRPLY  = 1'b1;
    bus.nAD_in = 16'hFFFF;
    forever begin
      @(negedge CLK);
      if (resp_en && !bus.nSYNC && (!bus.nDIN || !bus.nDOUT)) begin
        if (rcnt >= resp_delay) begin
          bus.nRPLY = 1'b0;
          if (!bus.nDOUT) cap_data = ~bus.nAD_out;
          else            bus.nAD_in = ~resp_data;
        end else begin
          rcnt++;
        end
      end else begin
        bus.nRPLY  = 1'b1;
        bus.nAD_in = 16'hFFFF;
        rcnt       = 0;
      end
    end
  end

  // Protocol monitor: counts acks, rule violations and strobe timing.
  initial begin
    forever begin
      @(negedge CLK);
      if (bus.ack) ack_cnt++;
      if (!bus.nDIN && !bus.nDOUT) viol++;
      if (!bus.nDIN && bus.nSYNC) viol++;
      if (!bus.nIAKO && bus.nDIN) viol++;
      if (!bus.nSYNC && bus.nAD_oe && !cur_write) viol++;
      if (!bus.nDOUT) dout_data = ~bus.nAD_out;
      if (!bus.nIAKO && !bus.nDIN) iak_seen = 1'b1;
      if (bus.nAD_oe) begin
        if (!oe_prev) begin gap_oe = oe_lo_run; addr_seen = ~bus.nAD_out; end
        oe_lo_run = 0;
      end else oe_lo_run++;
      oe_prev = bus.nAD_oe;
      if (!bus.nSYNC) begin
        if (sync_prev) begin sync_gap = sync_hi_run; bs_seen = bus.nBS; end
        sync_hi_run = 0;
      end else sync_hi_run++;
      sync_prev = bus.nSYNC;
      if (!bus.nDIN) din_lo_run++;
      else begin
        if (!din_prev) din_lo_len = din_lo_run;
        din_lo_run = 0;
      end
      din_prev = bus.nDIN;
    end
  end

  task automatic run_cycle(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d,
                           output bit got);
    @(negedge CLK);
    bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = d;
    cur_write = (o == OP_WRITE);
    @(negedge CLK);
    bus.req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (bus.ack) got = 1'b1;
      else @(negedge CLK);
    end
    @(negedge CLK);
  endtask

  bit got, got2;
  int a0, v0;

  // Directed test sequence.
  initial begin
    bus.req = 1'b0; bus.op = 2'b00; bus.addr = 16'h0000; bus.wdata = 16'h0000;
    repeat (3) @(negedge CLK);
    check("rst_strobes", {bus.nSYNC, bus.nDIN, bus.nDOUT, bus.nBS, bus.nIAKO}, 5'b11111);
    check("rst_oe", bus.nAD_oe, 1'b0);
    check("rst_nad", bus.nAD_out, 16'hFFFF);
    check("rst_flags", {bus.busy, bus.ack, bus.err}, 3'b000);
    check("rst_rdata", bus.rdata, 16'h0000);
    RST = 1'b0;
    @(negedge CLK);

    // Read from the I/O page, responder answers after 3 cycles
    resp_data = 16'o000200; resp_delay = 3; v0 = viol; a0 = ack_cnt;
    run_cycle(OP_READ, 16'o177560, 16'h0000, got);
    check("rd_ack", got, 1'b1);
    check("rd_rdata", bus.rdata, 16'o000200);
    check("rd_err", bus.err, 1'b0);
    check("rd_one_ack", ack_cnt - a0, 32'd1);
    check("rd_nbs", bs_seen, 1'b0);
    check("rd_addr", addr_seen, 16'o177560);
    check("rd_busy_after", bus.busy, 1'b0);
    check("rd_protocol", viol - v0, 32'd0);

    // Write to the I/O page
    a0 = ack_cnt;
    run_cycle(OP_WRITE, 16'o177566, 16'o000101, got);
    check("wr_ack", got, 1'b1);
    check("wr_err", bus.err, 1'b0);
    check("wr_addr", addr_seen, 16'o177566);
    check("wr_dout_data", dout_data, 16'o000101);
    check("wr_captured", cap_data, 16'o000101);
    check("wr_nbs", bs_seen, 1'b0);
    check("wr_one_ack", ack_cnt - a0, 32'd1);

    // Interrupt acknowledge, vector 060
    resp_data = 16'o000060; resp_delay = 1;
    run_cycle(OP_IAK, 16'o000000, 16'h0000, got);
    check("iak_ack", got, 1'b1);
    check("iak_vector", bus.rdata, 16'o000060);
    check("iak_err", bus.err, 1'b0);
    check("iak_nbs", bs_seen, 1'b1);
    check("iak_iako_din", iak_seen, 1'b1);

    // Read with no responder: timeout after 64 cycles of nDIN
    resp_en = 1'b0;
    run_cycle(OP_READ, 16'o001000, 16'h0000, got);
    check("tmo_ack", got, 1'b1);
    check("tmo_err", bus.err, 1'b1);
    check("tmo_rdata_held", bus.rdata, 16'o000060);
    check("tmo_din_cycles", din_lo_len, 32'd64);
    check("tmo_nbs", bs_seen, 1'b1);
    check("tmo_addr", addr_seen, 16'o001000);

    // Reset pulsed while a write is in its data strobe
    resp_en = 1'b1; resp_delay = 5; a0 = ack_cnt;
    @(negedge CLK);
    bus.req = 1'b1; bus.op = OP_WRITE; bus.addr = 16'o177566; bus.wdata = 16'o000777;
    cur_write = 1'b1;
    @(negedge CLK);
    bus.req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (!bus.nDOUT) got = 1'b1;
      else @(negedge CLK);
    end
    check("rstmid_reached_strb", got, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("rstmid_strobes", {bus.nSYNC, bus.nDIN, bus.nDOUT, bus.nBS, bus.nIAKO}, 5'b11111);
    check("rstmid_oe", bus.nAD_oe, 1'b0);
    check("rstmid_busy_ack", {bus.busy, bus.ack}, 2'b00);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check("rstmid_no_ack", ack_cnt - a0, 32'd0);
    check("rstmid_err", bus.err, 1'b0);

    resp_data = 16'o012345; resp_delay = 0;
    run_cycle(OP_READ, 16'o177560, 16'h0000, got);
    check("post_rst_ack", got, 1'b1);
    check("post_rst_rdata", bus.rdata, 16'o012345);
    check("post_rst_err", bus.err, 1'b0);

    // Back-to-back: req held high across a write then a read
    resp_data = 16'o000521; resp_delay = 2; a0 = ack_cnt;
    @(negedge CLK);
    bus.req = 1'b1; bus.op = OP_WRITE; bus.addr = 16'o176566; bus.wdata = 16'o000245;
    cur_write = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      if (bus.ack) got = 1'b1;
    end
    bus.op = OP_READ; bus.addr = 16'o176562;
    cur_write = 1'b0;
    @(negedge CLK);
    check("b2b_idle_oe", bus.nAD_oe, 1'b0);
    @(negedge CLK);
    check("b2b_second_busy", bus.busy, 1'b1);
    bus.req = 1'b0;
    got2 = 1'b0;
    for (int i = 0; i < 200 && !got2; i++) begin
      if (bus.ack) got2 = 1'b1;
      else @(negedge CLK);
    end
    @(negedge CLK);
    check("b2b_ack1", got, 1'b1);
    check("b2b_ack2", got2, 1'b1);
    check("b2b_two_acks", ack_cnt - a0, 32'd2);
    check("b2b_wr_data", cap_data, 16'o000245);
    check("b2b_rdata", bus.rdata, 16'o000521);
    check("b2b_rd_addr", addr_seen, 16'o176562);
    check("b2b_bus_idle", (gap_oe >= 1), 1'b1);
    check("b2b_sync_gap", (sync_gap >= 1), 1'b1);
    check("protocol_total", viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/qbus_master.md
Name: qbus_master

Overview:
- Synthesizable Q-bus initiator (bus master) that issues DATI (read), DATO (write) and interrupt-acknowledge (IAK) cycles on the inverted, multiplexed nAD bus.
- Drives the vp_065 serial controllers and any other Q-bus responders.
- A simple request/acknowledge port on the core side is converted into the full nSYNC/nDIN/nDOUT/nBS/nIAKO handshake, with a reply timeout.
- Sits between a CPU/DMA core and the board-level Q-bus pins.

Parameters:
- TMO_CYC, 64: clock cycles allowed waiting for each nRPLY edge before a bus error is declared (range 2..65535).
- IOPAGE_HI, 3'b111: value of addr[15:13] that selects the I/O page (nBS asserted).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- req  in  1  start-cycle request; sampled only in IDLE.
- op  in  2  cycle type: 00 read, 01 write, 10 IAK, 11 reserved (treated as read).
- addr  in  16  byte address, true polarity.
- wdata  in  16  write data, true polarity.
- busy  out  1  high from request acceptance until ack.
- ack  out  1  one-cycle pulse at cycle end.
- err  out  1  valid with ack; 1 = reply timeout.
- rdata  out  16  read data or IAK vector, true polarity; valid with ack, held until the next ack.
- nAD_out  out  16  inverted address/data to the pad.
- nAD_oe  out  1  pad driver enable.
- nAD_in  in  16  pad input.
- nSYNC, nDIN, nDOUT, nBS, nIAKO  out  1 each  bus strobes, active low.
- nRPLY  in  1  responder reply, asynchronous, active low.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; strobes (nSYNC, nDIN, nDOUT, nBS, nIAKO) = 1.
  - nAD_oe=0, nAD_out=16'hFFFF.
  - busy=0, ack=0, err=0, rdata=0, timeout counter=0.
  - Reset in the middle of a cycle releases every strobe immediately; no ack is issued.
- nRPLY passes through a 2-flop synchronizer (rply_s, active high when nRPLY=0). All waits use rply_s.
- States, one step per clock:
  - IDLE: on req, latch op/addr/wdata, set busy=1 -> ADDR.
  - ADDR (1 cycle): nAD_oe=1, nAD_out=~addr; nBS=0 if addr[15:13]==IOPAGE_HI and op!=IAK, otherwise nBS=1; nSYNC=1 -> SYNC. For IAK, nAD_oe=0 and nBS=1.
  - SYNC (1 cycle): nSYNC=0. For write, nAD_out=~wdata and oe stays 1. For read/IAK, nAD_oe=0 -> STRB.
  - STRB: read asserts nDIN=0; write asserts nDOUT=0; IAK asserts nDIN=0 and nIAKO=0. The counter is cleared on entry and increments each cycle.
    - rply_s=1 -> LATCH.
    - Counter reaches TMO_CYC-1 -> TERR.
  - LATCH (1 cycle): for read/IAK, rdata=~nAD_in. Deassert nSYNC, nDIN, nDOUT, nIAKO. Keep nBS and write data driven -> REL.
  - REL: wait for rply_s=0, using a counter restarted on entry.
    - Released -> END.
    - Timeout -> TERR.
  - TERR (1 cycle): all strobes released, err latched =1 -> END.
  - END (1 cycle): nAD_oe=0, nBS=1, ack=1, busy=0 -> IDLE. err stays valid with ack and is cleared on the next acceptance.
- Minimum latency, req to ack, with a zero-wait responder: 6 + 2 sync cycles per nRPLY edge.
- req held high in END is ignored. A new cycle is accepted in IDLE on the following clock, giving a minimum 1-cycle bus idle between cycles.
- nRPLY already low on entry to STRB: proceed to LATCH at once. nRPLY stuck low in REL: timeout.
- nSYNC is never low while nAD_oe carries an address for the read direction. Only one of nDIN/nDOUT is ever low.

Decomposition:
- qbus_pkg:
  - op codes OP_READ/OP_WRITE/OP_IAK;
  - state encoding localparams;
  - IOPAGE_HI default;
  - vector/timeout width constants.
- One natural sub-module: qbus_sync (2-flop synchronizer with async reset, reset value = inactive). The FSM, counter and datapath stay in qbus_master.

Test Plan:
- Read 177560, responder returns 000200 after 3 cycles -> nBS=0, nDIN low only after nSYNC low, rdata=000200, err=0, exactly one ack.
- Write 177566 data 000101 -> nAD shows ~177566 during ADDR and ~000101 while nDOUT low; responder captures 000101; ack, err=0.
- IAK, vp_065 chain presents vector 000060 -> nBS=1, nIAKO and nDIN low together, rdata=000060.
- Read 001000 with no responder, TMO_CYC=64 -> strobes released 64 cycles after STRB entry; ack with err=1, rdata unchanged.
- RST pulsed during STRB of a write -> all strobes 1 and nAD_oe=0 within the same cycle; no ack; next req completes normally.
- Back-to-back req held high for write 176566=000245 then read 176562 -> two acks, bus idle ≥1 cycle between them, nSYNC high at least one cycle between cycles.
